// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC operand feeder.
package mac_pkg;

  // Feeder sequencing: clear the MAC, stream VEC_LEN products, capture, hand off.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  // Accumulator holds three operand widths so long dot products wrap predictably.
  localparam int unsigned ACC_FACTOR = 3;

  function automatic int unsigned acc_width(input int unsigned data_width);
    return ACC_FACTOR * data_width;
  endfunction

endpackage

// File: rtl/mac_feeder.sv
// Initiator side of the MAC operand/accumulate interface: pairs A and B operands,
// drives one MAC lane for VEC_LEN products and returns the accumulated dot product.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LEN    = 8,
  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_ain,
  output logic [DATA_WIDTH-1:0] mac_bin,
  input  logic [ACC_WIDTH-1:0]  mac_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data
);

  localparam int unsigned CNT_WIDTH = $clog2(VEC_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VEC_LEN - 1);

  state_e               state;
  logic [CNT_WIDTH-1:0] count;
  logic                 in_accum;
  logic                 fire;

  // A and B only ever move together; a lone valid is never acknowledged.
  always_comb begin
    in_accum = (state == ACCUM);
    fire     = in_accum & a_valid & b_valid;
    a_ready  = fire;
    b_ready  = fire;
    mac_en   = fire;
    mac_clr  = (state == CLEAR);
    busy     = (state != IDLE);
    mac_ain  = in_accum ? a_data : '0;
    mac_bin  = in_accum ? b_data : '0;
  end

  // Sequencer, product counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          count <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          if (fire) begin
            count <= count + 1'b1;
            if (count == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          // mac_cout already includes the last product enabled in ACCUM.
          res_data  <= mac_cout;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Initiator side of the MAC operand/accumulate interface.
- Accepts one A-row stream and one B-vector stream over valid/ready handshakes and drives mac_en, mac_clr, mac_ain and mac_bin into a MAC.
- Reads back the accumulator after VEC_LEN products and presents the dot product on a valid/ready result port.
- Sits between the operand FIFOs and each MAC lane of the matrix-vector datapath.

Parameters:
DATA_WIDTH, 8, operand width; accumulator/result width is 3*DATA_WIDTH
VEC_LEN, 8, products accumulated per result; legal range is 1 or more

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin one dot product; sampled only in IDLE
busy  output  1  high in every state except IDLE
a_valid  input  1  A operand valid
a_ready  output  1  A operand accepted this cycle
a_data  input  DATA_WIDTH  A operand
b_valid  input  1  B operand valid
b_ready  output  1  B operand accepted this cycle
b_data  input  DATA_WIDTH  B operand
mac_en  output  1  to MAC: accumulate Ain*Bin at this edge
mac_clr  output  1  to MAC: clear accumulator at this edge
mac_ain  output  DATA_WIDTH  to MAC Ain
mac_bin  output  DATA_WIDTH  to MAC Bin
mac_cout  input  3*DATA_WIDTH  from MAC Cout (registered accumulator)
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  3*DATA_WIDTH  dot-product result (registered)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, count=0, res_valid=0, res_data=0. busy, a_ready, b_ready, mac_en and mac_clr are all 0. Mid-operation reset abandons the dot product silently.
- MAC contract: when mac_en=1 at an edge, the MAC accumulator takes Acc+Ain*Bin. mac_clr has priority over mac_en. mac_cout reflects the update one cycle after the enabling edge.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: one cycle, mac_clr=1, count<=0 -> ACCUM.
  - ACCUM:
    - fire = a_valid & b_valid. a_ready = b_ready = mac_en = fire.
    - mac_ain=a_data and mac_bin=b_data (combinational pass-through).
    - A and B transfer only jointly; a lone valid is never acknowledged.
    - On fire, count++. Fire with count==VEC_LEN-1 -> DRAIN.
  - DRAIN: one cycle, res_data<=mac_cout, res_valid<=1 -> DONE.
  - DONE: hold res_valid and res_data stable until res_ready=1. On handshake, res_valid<=0 -> IDLE.
- Outside ACCUM: a_ready=b_ready=mac_en=0 and mac_ain=mac_bin=0. mac_clr=1 only in CLEAR.
- start outside IDLE is ignored. start held high in IDLE launches again one cycle after returning to IDLE.
- Latency with back-to-back valids: start sampled at cycle 0 gives res_valid=1 at cycle VEC_LEN+3. Throughput is one product per cycle.
- Stalls: operand bubbles in ACCUM extend latency one cycle each. No timeout.
- Arithmetic: unsigned. Result is modulo 2^(3*DATA_WIDTH) with no saturation, so it equals mac_cout exactly.
- Counter width: $clog2(VEC_LEN+1). VEC_LEN=1 goes CLEAR -> ACCUM (one fire) -> DRAIN.
- res_ready while res_valid=0 has no effect.

Decomposition:
- Package mac_pkg: state enum typedef (IDLE, CLEAR, ACCUM, DRAIN, DONE) and localparam ACC_WIDTH = 3*DATA_WIDTH helper.
- No RTL sub-module; FSM, counter and result register live in one module.
- Benches instantiate mac_feeder wired to the existing MAC module (same clk/rst_n) to close the loop.

Test Plan:
- DW=8, VEC_LEN=8, a=b=1..8, valids held high, res_ready=1 -> res_data=204; res_valid at cycle 11 after start; exactly 8 mac_en pulses; one mac_clr pulse.
- All operands 255 -> res_data=520200. A second start then uses a=b=1 -> res_data=8, proving CLEAR wipes the prior accumulator.
- Random bubbles: a_valid and b_valid toggled independently -> ready only when both valid; result still 204; count of fires equals 8.
- res_ready held 0 for 5 cycles in DONE -> res_valid and res_data stable. start pulses during DONE are ignored; IDLE is entered only after the handshake.
- DATA_WIDTH=4, VEC_LEN=19, all operands 15 -> res_data=179 (4275 mod 4096). VEC_LEN=1, a=3, b=7 -> res_data=21.
- rst_n asserted after 4 fires -> all outputs 0 immediately. After release with new start and a=b=1..8 -> 204.
